hex_scan_driver: RTL and testbench

Time-multiplexed scan driver for a bank of common-cathode 7-segment digits. It captures a multi-digit hexadecimal value and cycles through the digits at a programmable refresh rate. Each scan slot presents one 4-bit nibble to the downstream binary-to-7-segment decoder and drives the matching active-low digit select. Value updates are deferred to a scan-frame boundary so the display never tears, and leading zeros can be blanked.

---
 rtl/hex_scan_driver.sv | 126 ++++++++++++
 tb/tb_hex_scan_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_driver.sv
// ---------------------------------------------------------------------------
// hex_scan_driver
//
// Time-multiplexed scan driver for a bank of common-cathode 7-segment digits.
// A multi-digit hex value is captured into a shadow register on `load` and
// copied to the display register only at a scan-frame boundary, so a frame
// never shows a mix of old and new digits. Each slot presents one nibble to
// the downstream 7-segment decoder and pulls the matching digit select low,
// after a short guard at the start of the slot to suppress ghosting.
//
// Parameters:
//   NUM_DIGITS   - digits in the bank (2..8); digit 0 is the LS nibble
//   REFRESH_DIV  - clock cycles per digit slot (>= 2)
//   BLANK_CYCLES - guard cycles at the start of each slot (< REFRESH_DIV)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   value_in     in   4*NUM_DIGITS value to display, nibble k -> digit k
//   load         in   single-cycle strobe capturing value_in
//   blank_lz     in   leading-zero blanking enable (quasi-static)
//   digit_out    out  nibble of the current slot (decoder input)
//   digit_sel_n  out  active-low digit enables, at most one bit low
//   pending      out  a loaded value is waiting for the frame boundary
// ---------------------------------------------------------------------------
module hex_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    pending
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shd;
  logic [4*NUM_DIGITS-1:0] disp;

  logic tick;
  logic frame_end;

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  // Scan timing and the shadow/display double buffer. A load that lands on
  // the frame boundary bypasses the shadow so it shows in the very next slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      shd     <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end

      if (load && frame_end) begin
        shd     <= value_in;
        disp    <= value_in;
        pending <= 1'b0;
      end else if (load) begin
        shd     <= value_in;
        pending <= 1'b1;
      end else if (frame_end) begin
        disp    <= shd;
        pending <= 1'b0;
      end
    end
  end

  // upper_zero[k] is set when nibbles k..NUM_DIGITS-1 of disp are all zero,
  // i.e. digit k is a leading zero.
  logic [NUM_DIGITS-1:0] upper_zero;

  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc           = acc & (disp[4*k +: 4] == 4'h0);
      upper_zero[k] = acc;
    end
  end

  // Guard window at the start of every slot; with no guard it never fires.
  logic guard;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_guard
      assign guard = 1'b0;
    end else begin : g_guard
      assign guard = (cnt < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  logic blanked;

  // Digit 0 always lights so an all-zero value still shows a single "0".
  assign blanked = blank_lz && (idx != '0) && upper_zero[idx];

  always_comb begin
    digit_out = disp[4*idx +: 4];
    if (blanked || guard) begin
      digit_sel_n = '1;
    end else begin
      digit_sel_n = ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
module tb_hex_scan_driver;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * R;

  logic          clk;
  logic          rst_n;
  logic [15:0]   value_in;
  logic          load;
  logic          blank_lz;
  logic [3:0]    digit_out;
  logic [N-1:0]  digit_sel_n;
  logic          pending;

  hex_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .digit_out  (digit_out),
    .digit_sel_n(digit_sel_n),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: elapsed cycles since reset fully determine slot,
  // position in slot and frame boundaries; the buffers follow the load rules.
  int          m_t = 0;
  logic [15:0] m_shd = '0;
  logic [15:0] m_disp = '0;
  logic        m_pend = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_fe;

  assign m_fe = ((m_t % FRAME) == FRAME - 1);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t     <= 0;
      m_shd   <= '0;
      m_disp  <= '0;
      m_pend  <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      m_t <= m_t + 1;
      if (load) m_shd <= value_in;
      if (m_fe) m_disp <= load ? value_in : m_shd;
      if (m_fe) m_pend <= 1'b0;
      else if (load) m_pend <= 1'b1;
    end
  end

  function automatic logic [3:0] exp_digit(input int t, input logic [15:0] d);
    int slot;
    slot = (t / R) % N;
    return 4'((d >> (4 * slot)) & 16'hF);
  endfunction

  function automatic logic [N-1:0] exp_sel(input int t, input logic [15:0] d, input logic blz);
    int   slot;
    int   pos;
    logic blanked;
    slot    = (t / R) % N;
    pos     = t % R;
    blanked = blz && (slot != 0) && ((d >> (4 * slot)) == 16'h0);
    if (blanked || pos < BC) return '1;
    return ~(N'(1) << slot);
  endfunction

  // Continuous comparison away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("digit_out", 32'(digit_out), 32'(exp_digit(m_t, m_disp)));
      check("digit_sel_n", 32'(digit_sel_n), 32'(exp_sel(m_t, m_disp, blank_lz)));
      check("pending", 32'(pending), 32'(m_pend));
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_t(input int target);
    if (target > m_t) adv(target - m_t);
  endtask

  task automatic do_load(input logic [15:0] v);
    value_in = v;
    load     = 1'b1;
    adv(1);
    load     = 1'b0;
    value_in = 16'($urandom);
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    blank_lz = 1'b0;
    value_in = 16'h0;
    adv(1);
    rst_n = 1'b1;

    // Reset then idle scan
    check("rst_sel", 32'(digit_sel_n), 32'h0000000F);
    check("rst_out", 32'(digit_out), 32'h0);
    check("rst_pend", 32'(pending), 32'h0);
    adv(2);  check("idle_sel_t2", 32'(digit_sel_n), 32'hE);
    adv(8);  check("idle_sel_t10", 32'(digit_sel_n), 32'hD);
    adv(8);  check("idle_sel_t18", 32'(digit_sel_n), 32'hB);
    adv(8);  check("idle_sel_t26", 32'(digit_sel_n), 32'h7);
    adv(8);  check("idle_sel_t34", 32'(digit_sel_n), 32'hE);

    // Mid-frame load
    do_load(16'h1A3F);
    check("ld_pend_rise", 32'(pending), 32'h1);
    goto_t(63); check("ld_pend_hold", 32'(pending), 32'h1);
    goto_t(64); check("ld_pend_fall", 32'(pending), 32'h0);
    check("ld_d0", 32'(digit_out), 32'hF);
    goto_t(72); check("ld_d1", 32'(digit_out), 32'h3);
    goto_t(80); check("ld_d2", 32'(digit_out), 32'hA);
    goto_t(88); check("ld_d3", 32'(digit_out), 32'h1);

    // Two loads within one frame
    do_load(16'h1111);
    goto_t(90);
    do_load(16'h2222);
    goto_t(95); check("dbl_pend", 32'(pending), 32'h1);
    goto_t(96); check("dbl_pend_fall", 32'(pending), 32'h0);
    check("dbl_d0", 32'(digit_out), 32'h2);

    // Load on the frame_end cycle bypasses the shadow
    goto_t(127);
    do_load(16'h0BEE);
    check("byp_pend", 32'(pending), 32'h0);
    check("byp_d0", 32'(digit_out), 32'hE);
    goto_t(136); check("byp_d1", 32'(digit_out), 32'hE);
    goto_t(144); check("byp_d2", 32'(digit_out), 32'hB);
    goto_t(152); check("byp_d3", 32'(digit_out), 32'h0);

    // Leading-zero blanking
    blank_lz = 1'b1;
    goto_t(159); do_load(16'h0005);
    goto_t(162); check("lz5_s0_sel", 32'(digit_sel_n), 32'hE);
    check("lz5_s0_out", 32'(digit_out), 32'h5);
    goto_t(170); check("lz5_s1_sel", 32'(digit_sel_n), 32'hF);
    goto_t(186); check("lz5_s3_sel", 32'(digit_sel_n), 32'hF);
    goto_t(191); do_load(16'h0000);
    goto_t(194); check("lz0_s0_sel", 32'(digit_sel_n), 32'hE);
    goto_t(202); check("lz0_s1_sel", 32'(digit_sel_n), 32'hF);
    goto_t(223); do_load(16'h0100);
    goto_t(226); check("lz100_s0", 32'(digit_sel_n), 32'hE);
    goto_t(234); check("lz100_s1", 32'(digit_sel_n), 32'hD);
    goto_t(242); check("lz100_s2", 32'(digit_sel_n), 32'hB);
    goto_t(250); check("lz100_s3", 32'(digit_sel_n), 32'hF);
    blank_lz = 1'b0;

    // Reset mid-slot 2 with a pending value, load held during reset
    goto_t(260); do_load(16'hABCD);
    goto_t(275); check("rst_pre_pend", 32'(pending), 32'h1);
    rst_n    = 1'b0;
    load     = 1'b1;
    value_in = 16'hFFFF;
    adv(1);
    rst_n = 1'b1;
    load  = 1'b0;
    check("rst2_pend", 32'(pending), 32'h0);
    check("rst2_out", 32'(digit_out), 32'h0);
    check("rst2_sel", 32'(digit_sel_n), 32'hF);
    goto_t(34); check("rst2_f1_out", 32'(digit_out), 32'h0);
    goto_t(58); check("rst2_f1_out3", 32'(digit_out), 32'h0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        value_in = 16'($urandom);
        if ($urandom_range(0, 3) == 0) value_in[15:8] = 8'h0;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) blank_lz = ~blank_lz;
      rst_n = ($urandom_range(0, 599) != 0);
      adv(1);
    end
    load  = 1'b0;
    rst_n = 1'b1;
    adv(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
